// File: rtl/ictrl_ibuffer_noc_reader_if.sv
// NoC read port towards the ibuffer arbiter plus the outgoing instruction stream.
// master = burst reader, slave = arbiter/stream sink.
interface ictrl_ibuffer_noc_reader_if #(
   parameter int DATA_WIDTH = 128,
   parameter int MEM_AW     = 15
);
   logic                  rd_cen;
   logic                  rd_wen;
   logic                  rd_ready;
   logic [MEM_AW-1:0]     rd_addr;
   logic [DATA_WIDTH-1:0] rd_rdata;
   logic                  rd_rvalid;
   logic                  rd_rready;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;
   logic                  out_ready;

   modport master (
      output rd_cen, rd_wen, rd_addr, rd_rready, out_valid, out_data, out_last,
      input  rd_ready, rd_rdata, rd_rvalid, out_ready
   );

   modport slave (
      input  rd_cen, rd_wen, rd_addr, rd_rready, out_valid, out_data, out_last,
      output rd_ready, rd_rdata, rd_rvalid, out_ready
   );
endinterface

// File: rtl/ictrl_ibuffer_noc_reader.sv
// Burst reader: turns one start command into credit-limited ibuffer reads and
// streams the returned words out through a small FIFO with a last-beat flag.
module ictrl_ibuffer_noc_reader #(
   parameter int DATA_WIDTH = 128,
   parameter int MEM_AW     = 15,
   parameter int LEN_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [MEM_AW-1:0]       base_addr,
   input  logic [LEN_W-1:0]        length,
   output logic                    busy,
   output logic                    done,
   ictrl_ibuffer_noc_reader_if.master bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]    CNT_DEPTH = CW'(FIFO_DEPTH);
   localparam logic [CW:0]      OCC_DEPTH = (CW+1)'(FIFO_DEPTH);
   localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
   localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

   state_t                state_r, state_s;
   logic [MEM_AW-1:0]     base_r;
   logic [LEN_W-1:0]      len_r, issue_cnt_r, sent_cnt_r;
   logic [CW-1:0]         inflight_r, count_r;
   logic [PW-1:0]         wr_ptr_r, rd_ptr_r;
   logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
   logic                  busy_r, done_r;
   logic                  accept_s, done_set_s, req_s, push_s, pop_s;
   logic                  is_last_s, final_pop_s, credit_s;
   logic [CW:0]           occupancy_s;

   // Every request already made plus every buffered word must fit in the FIFO.
   assign occupancy_s = {1'b0, inflight_r} + {1'b0, count_r};
   assign credit_s    = occupancy_s < OCC_DEPTH;

   assign bus.rd_cen    = (state_r == ISSUE) && (issue_cnt_r < len_r) && credit_s;
   assign bus.rd_wen    = 1'b0;
   assign bus.rd_addr   = base_r + MEM_AW'(issue_cnt_r);
   assign bus.rd_rready = (count_r != CNT_DEPTH);
   assign bus.out_valid = (count_r != CNT_ZERO);
   assign bus.out_data  = mem_r[rd_ptr_r];
   assign bus.out_last  = bus.out_valid && is_last_s;

   assign req_s       = bus.rd_cen && bus.rd_ready;
   // Returns with nothing outstanding are swallowed rather than buffered.
   assign push_s      = bus.rd_rvalid && bus.rd_rready && (inflight_r != CNT_ZERO);
   assign pop_s       = bus.out_valid && bus.out_ready;
   assign is_last_s   = (sent_cnt_r == (len_r - LEN_ONE));
   assign final_pop_s = pop_s && is_last_s;

   assign busy = busy_r;
   assign done = done_r;

   // Next-state decode; done_set_s schedules the done pulse for the following cycle.
   always_comb begin
      state_s    = state_r;
      accept_s   = 1'b0;
      done_set_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               accept_s = 1'b1;
               state_s  = (length == LEN_ZERO) ? FIN : ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (final_pop_s) begin
               state_s    = FIN;
               done_set_s = 1'b1;
            end else if (issue_cnt_r == len_r) begin
               state_s = DRAIN;
            end else begin
               state_s = ISSUE;
            end
         end
         DRAIN: begin
            if (final_pop_s || (sent_cnt_r == len_r)) begin
               state_s    = FIN;
               done_set_s = 1'b1;
            end else begin
               state_s = DRAIN;
            end
         end
         FIN: begin
            // busy still high here only on the empty-burst path, whose pulse is still owed.
            done_set_s = busy_r;
            if (start && !busy_r) begin
               accept_s = 1'b1;
               state_s  = (length == LEN_ZERO) ? FIN : ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Control state, latched command and burst progress counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         base_r      <= {MEM_AW{1'b0}};
         len_r       <= LEN_ZERO;
         issue_cnt_r <= LEN_ZERO;
         sent_cnt_r  <= LEN_ZERO;
         inflight_r  <= CNT_ZERO;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != IDLE) && !done_set_s;
         done_r  <= done_set_s;
         if (accept_s) begin
            base_r      <= base_addr;
            len_r       <= length;
            issue_cnt_r <= LEN_ZERO;
            sent_cnt_r  <= LEN_ZERO;
         end else begin
            if (req_s) issue_cnt_r <= issue_cnt_r + LEN_ONE;
            if (pop_s) sent_cnt_r <= sent_cnt_r + LEN_ONE;
         end
         case ({req_s, push_s})
            2'b10:   inflight_r <= inflight_r + CNT_ONE;
            2'b01:   inflight_r <= inflight_r - CNT_ONE;
            default: inflight_r <= inflight_r;
         endcase
      end
   end

   // Return FIFO: storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {DATA_WIDTH{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= CNT_ZERO;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= bus.rd_rdata;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

// File: tb/tb_ictrl_ibuffer_noc_reader.sv
// Scoreboard bench for ictrl_ibuffer_noc_reader: a memory-model responder,
// randomized backpressure and an in-order expected-beat queue.
module tb_ictrl_ibuffer_noc_reader;
   localparam int DW = 128, AW = 15, LW = 16, DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [LW-1:0] length = '0;
   logic          busy, done;

   ictrl_ibuffer_noc_reader_if #(.DATA_WIDTH(DW), .MEM_AW(AW)) bus ();

   ictrl_ibuffer_noc_reader #(.DATA_WIDTH(DW), .MEM_AW(AW), .LEN_W(LW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .length(length), .busy(busy), .done(done), .bus(bus)
   );

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [DW-1:0] data; int due; } ret_t;
   typedef struct { logic [DW-1:0] data; logic last; } exp_t;
   ret_t          ret_q[$];
   exp_t          exp_q[$];
   logic [AW-1:0] addr_q[$];

   int asserts = 0, errors = 0;
   int unsigned salt;
   int rd_rand = 0, lat_max = 1, or_mode = 0;
   int reqs_m = 0, pops_m = 0, req_first = -1, req_last = -1;
   int exp_done_cyc = -1, dones = 0;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      logic [31:0] x;
      x = 32'(a);
      return {salt ^ x, x * 32'h9E3779B1, ~x, salt + x};
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      asserts++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Responder: memory model with random return latency and optional rd_ready toggling.
   initial begin
      bus.rd_ready = 1'b1; bus.rd_rvalid = 1'b0; bus.rd_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (bus.rd_cen && bus.rd_ready)
               ret_q.push_back('{mem_word(bus.rd_addr), cyc + int'($urandom_range(lat_max, 1))});
            if (bus.rd_rvalid && bus.rd_rready && ret_q.size() > 0) void'(ret_q.pop_front());
         end
         @(posedge clk); #1;
         bus.rd_ready = (rd_rand != 0) ? 1'($urandom_range(1, 0)) : 1'b1;
         if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            bus.rd_rvalid = 1'b1; bus.rd_rdata = ret_q[0].data;
         end else begin
            bus.rd_rvalid = 1'b0;
         end
      end
   end

   // Stream sink backpressure.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (or_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'($urandom_range(1, 0));
         endcase
      end
   end

   // Monitor: addresses, credit, beats, hold stability and done timing.
   initial begin
      logic          hold_p;
      logic [DW-1:0] hold_d;
      logic          hold_l;
      exp_t          e;
      hold_p = 1'b0; hold_d = '0; hold_l = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            hold_p = 1'b0;
         end else begin
            if (bus.rd_cen) check("credit", ((reqs_m - pops_m) < DEPTH), 1'b1);
            if (bus.rd_cen && bus.rd_ready) begin
               if (addr_q.size() == 0) check("extra_req", 0, 1);
               else check("rd_addr", bus.rd_addr, addr_q.pop_front());
               reqs_m++;
               if (req_first < 0) req_first = cyc;
               req_last = cyc;
            end
            if (hold_p && bus.out_valid) begin
               check("hold_data", bus.out_data, hold_d);
               check("hold_last", bus.out_last, hold_l);
            end
            if (bus.out_valid && bus.out_ready) begin
               pops_m++;
               if (exp_q.size() == 0) check("extra_beat", 0, 1);
               else begin
                  e = exp_q.pop_front();
                  check("out_data", bus.out_data, e.data);
                  check("out_last", bus.out_last, e.last);
                  if (e.last) exp_done_cyc = cyc + 1;
               end
            end
            hold_p = bus.out_valid && !bus.out_ready;
            hold_d = bus.out_data; hold_l = bus.out_last;
            if (done) begin
               dones++;
               check("done_cycle", cyc, exp_done_cyc);
               check("busy_at_done", busy, 1'b0);
               exp_done_cyc = -1;
            end
         end
      end
   end

   task automatic start_burst(input logic [AW-1:0] b, input logic [LW-1:0] l, output int c0);
      logic [AW-1:0] a;
      @(posedge clk); #2;
      for (int i = 0; i < int'(l); i++) begin
         a = b + AW'(i);
         addr_q.push_back(a);
         exp_q.push_back('{mem_word(a), (i == int'(l) - 1)});
      end
      if (l == 0) exp_done_cyc = cyc + 2;
      req_first = -1;
      c0 = cyc;
      start = 1'b1; base_addr = b; length = l;
      @(posedge clk); #2;
      start = 1'b0; base_addr = AW'($urandom); length = LW'($urandom);
      @(negedge clk);
      check("busy_cycle1", busy, 1'b1);
      check("rd_cen_cycle1", bus.rd_cen, (l != 0));
   endtask

   task automatic finish_burst(input int d0);
      int n;
      n = 0;
      while (dones == d0 && n < 3000) begin
         @(negedge clk); n++;
      end
      if (n >= 3000) check("done_timeout", 0, 1);
      repeat (3) @(negedge clk);
      check("done_count", dones, d0 + 1);
      check("beats_left", exp_q.size(), 0);
      check("reqs_left", addr_q.size(), 0);
   endtask

   task automatic run_burst(input logic [AW-1:0] b, input logic [LW-1:0] l);
      int d0, c0;
      d0 = dones;
      start_burst(b, l, c0);
      finish_burst(d0);
   endtask

   initial begin
      #(50000 * 10);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int d0, c0, r0;
      salt  = $urandom;
      rst_n = 1'b0;
      #7;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rd_cen", bus.rd_cen, 1'b0);
      check("rst_rd_wen", bus.rd_wen, 1'b0);
      check("rst_rd_addr", bus.rd_addr, 0);
      check("rst_rd_rready", bus.rd_rready, 1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_last", bus.out_last, 1'b0);
      check("rst_out_data", bus.out_data, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Full-rate burst: one request per cycle starting in cycle 1.
      d0 = dones;
      start_burst(15'h0010, 16'd5, c0);
      finish_burst(d0);
      check("first_req_cycle", req_first, c0 + 1);
      check("last_req_cycle", req_last, c0 + 5);

      // Empty burst.
      r0 = reqs_m;
      run_burst(15'h0123, 16'd0);
      check("len0_no_req", reqs_m, r0);

      // Address wrap.
      run_burst(15'h7FFE, 16'd4);

      // Stalled sink: credit limits outstanding requests.
      or_mode = 1; r0 = reqs_m; d0 = dones;
      start_burst(15'h0100, 16'd10, c0);
      repeat (20) @(negedge clk);
      check("stall_reqs", reqs_m - r0, DEPTH);
      or_mode = 0;
      finish_burst(d0);

      // Random rd_ready, latency 1..3, long burst, plus a dropped start while busy.
      rd_rand = 1; lat_max = 3; d0 = dones;
      start_burst(AW'($urandom), 16'd64, c0);
      repeat (8) @(negedge clk);
      #1; start = 1'b1; base_addr = AW'($urandom); length = 16'd7;
      @(negedge clk); #1; start = 1'b0;
      finish_burst(d0);

      // Random bursts with random backpressure on both sides.
      for (int k = 0; k < 3; k++) begin
         rd_rand = int'($urandom_range(1, 0)); lat_max = int'($urandom_range(3, 1));
         or_mode = 2;
         run_burst(AW'($urandom), LW'($urandom_range(40, 1)));
      end
      or_mode = 0; rd_rand = 0; lat_max = 1;

      // Reset mid-burst, then a clean short burst.
      or_mode = 1;
      start_burst(15'h0200, 16'd10, c0);
      repeat (5) @(negedge clk);
      d0 = dones;
      #1; rst_n = 1'b0;
      ret_q.delete(); exp_q.delete(); addr_q.delete();
      reqs_m = 0; pops_m = 0; exp_done_cyc = -1;
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_rd_cen", bus.rd_cen, 1'b0);
      check("mid_rst_rd_addr", bus.rd_addr, 0);
      check("mid_rst_out_valid", bus.out_valid, 1'b0);
      check("mid_rst_out_data", bus.out_data, 0);
      check("mid_rst_rd_rready", bus.rd_rready, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1; or_mode = 0;
      repeat (2) @(negedge clk);
      check("abort_no_done", dones, d0);
      run_burst(15'h0300, 16'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
      $finish;
   end
endmodule
